// File: rtl/dct_pkg.sv
// dct_pkg: shared state encoding and data widths for the DCT array controller
package dct_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;
    localparam int ACC_W = 64;
    localparam int OPD_W = 32;
endpackage

// File: rtl/dct_feed_skew.sv
// dct_feed_skew: per-row skewed west operand enables and step indices from the step counter
module dct_feed_skew #(
    parameter  int N  = 8,
    parameter  int K  = 8,
    localparam int TW = $clog2(K + N - 1),
    localparam int KW = (K > 1) ? $clog2(K) : 1
) (
    input  logic            active,
    input  logic [TW-1:0]   t,
    output logic [N-1:0]    west_en,
    output logic [N*KW-1:0] west_idx
);
    always_comb begin
        west_en  = '0;
        west_idx = '0;
        for (int i = 0; i < N; i++) begin
            west_en[i]            = active && (int'(t) >= i) && (int'(t) < i + K);
            west_idx[i*KW +: KW]  = west_en[i] ? KW'(int'(t) - i) : '0;
        end
    end
endmodule

// File: rtl/dct_array_ctrl.sv
// dct_array_ctrl: clear/compute/drain job controller for the NxN systolic MAC array
// Optional DCT_ARRAY_CTRL_PERF_EN adds a saturating busy-cycle counter output perf_cycles.
module dct_array_ctrl
    import dct_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int K  = 8,
    localparam int TW = $clog2(K + N - 1),
    localparam int KW = (K > 1) ? $clog2(K) : 1,
    localparam int NW = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  pe_clr,
    output logic                  north_en,
    output logic [KW-1:0]         north_idx,
    output logic [N-1:0]          west_en,
    output logic [N*KW-1:0]       west_idx,
    input  logic [N*N*ACC_W-1:0]  pe_result,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [NW-1:0]         res_row,
    output logic [NW-1:0]         res_col,
    output logic [ACC_W-1:0]      res_data
`ifdef DCT_ARRAY_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_cycles
`endif
);
    localparam logic [TW-1:0] T_LAST = TW'(K + N - 2);

    state_t        state;
    logic [TW-1:0] t;
    logic          compute, last_col, last_row;

    assign compute   = state == COMPUTE;
    assign ready     = state == IDLE;
    assign busy      = !ready;
    assign done      = state == DONE;
    assign pe_clr    = state == CLEAR;
    assign res_valid = state == DRAIN;
    assign north_en  = compute && (t < TW'(K));
    assign north_idx = compute ? t[KW-1:0] : '0;
    assign last_col  = res_col == NW'(N - 1);
    assign last_row  = res_row == NW'(N - 1);
    assign res_data  = pe_result[(int'(res_row) * N + int'(res_col)) * ACC_W +: ACC_W];

    dct_feed_skew #(.N(N), .K(K)) u_skew (
        .active   (compute),
        .t        (t),
        .west_en  (west_en),
        .west_idx (west_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            t       <= '0;
            res_row <= '0;
            res_col <= '0;
        end else begin
            case (state)
                IDLE:    if (start) state <= CLEAR;
                CLEAR: begin
                    state <= COMPUTE;
                    t     <= '0;
                end
                COMPUTE: begin
                    t <= t + 1'b1;
                    if (t == T_LAST) state <= DRAIN;
                end
                DRAIN: if (res_ready) begin
                    // wrap coordinates to (0,0) so the next job starts clean
                    res_col <= last_col ? '0 : res_col + 1'b1;
                    if (last_col) res_row <= last_row ? '0 : res_row + 1'b1;
                    if (last_col && last_row) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCT_ARRAY_CTRL_PERF_EN
    logic [31:0] cnt, cnt_inc;

    assign cnt_inc = &cnt ? cnt : cnt + 32'd1;

    // DONE is the last non-idle cycle, so its increment is folded into the latched value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            perf_cycles <= '0;
        end else if (state == DONE) begin
            cnt         <= '0;
            perf_cycles <= cnt_inc;
        end else if (state != IDLE) begin
            cnt <= cnt_inc;
        end
    end
`endif
endmodule

// File: tb/tb_dct_array_ctrl.sv
// tb_dct_array_ctrl: directed/randomized self-checking bench for dct_array_ctrl (N=K=4)
module tb_dct_array_ctrl;
    localparam int N  = 4;
    localparam int K  = 4;
    localparam int KW = 2;
    localparam int NW = 2;

    logic              clk = 1'b0;
    logic              rst, start, res_ready;
    logic              ready, busy, done, pe_clr, north_en, res_valid;
    logic [KW-1:0]     north_idx;
    logic [N-1:0]      west_en;
    logic [N*KW-1:0]   west_idx;
    logic [N*N*64-1:0] pe_result;
    logic [NW-1:0]     res_row, res_col;
    logic [63:0]       res_data;
    logic [63:0]       pe_mem [N*N];
`ifdef DCT_ARRAY_CTRL_PERF_EN
    logic [31:0]       perf_cycles;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int cur    = 0;

    dct_array_ctrl #(.N(N), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .pe_clr    (pe_clr),
        .north_en  (north_en),
        .north_idx (north_idx),
        .west_en   (west_en),
        .west_idx  (west_idx),
        .pe_result (pe_result),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_row   (res_row),
        .res_col   (res_col),
        .res_data  (res_data)
`ifdef DCT_ARRAY_CTRL_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @%0d: observed %0h expected %0h", tag, cur, obs, exp);
        end
    endtask

    task automatic load_pe();
        for (int j = 0; j < N * N; j++) begin
            pe_mem[j] = {$urandom, $urandom};
            pe_result[j*64 +: 64] = pe_mem[j];
        end
    endtask

    task automatic check_reset();
        cur = -1;
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pe_clr", pe_clr, 0);
        chk("rst_north_en", north_en, 0);
        chk("rst_north_idx", north_idx, 0);
        chk("rst_west_en", west_en, 0);
        chk("rst_west_idx", west_idx, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_row", res_row, 0);
        chk("rst_res_col", res_col, 0);
        chk("rst_res_data", res_data, pe_mem[0]);
    endtask

    // Expected outputs for cycle c of a job started at cycle 0 with res_ready held high
    task automatic check_cycle(int c);
        int t, b, dc;
        bit cmp, dr;
        logic [N-1:0]    we;
        logic [N*KW-1:0] wi;
        cur = c;
        dc  = K + N + 1 + N * N;
        t   = c - 2;
        cmp = (c >= 2) && (c <= K + N);
        b   = c - (K + N + 1);
        dr  = (b >= 0) && (b < N * N);
        we  = '0;
        wi  = '0;
        for (int i = 0; i < N; i++)
            if (cmp && t >= i && t < i + K) begin
                we[i] = 1'b1;
                wi[i*KW +: KW] = KW'(t - i);
            end
        chk("ready", ready, (c > dc) ? 1 : 0);
        chk("busy", busy, (c >= 1 && c <= dc) ? 1 : 0);
        chk("done", done, (c == dc) ? 1 : 0);
        chk("pe_clr", pe_clr, (c == 1) ? 1 : 0);
        chk("north_en", north_en, (cmp && t < K) ? 1 : 0);
        chk("north_idx", north_idx, cmp ? t % (1 << KW) : 0);
        chk("west_en", west_en, we);
        chk("west_idx", west_idx, wi);
        chk("res_valid", res_valid, dr ? 1 : 0);
        if (dr || b < 0) begin
            chk("res_row", res_row, dr ? b / N : 0);
            chk("res_col", res_col, dr ? b % N : 0);
            chk("res_data", res_data, pe_mem[dr ? b : 0]);
        end
    endtask

    task automatic run_job();
        @(negedge clk);
        start = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= K + N + N * N + 2; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            check_cycle(c);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx, k, dones, fv, busy_after;
        bit fin;
        logic [3:0] pat;
        rst = 1'b1;
        start = 1'b0;
        res_ready = 1'b0;
        load_pe();
        @(negedge clk);
        check_reset();
        rst = 1'b0;

        // nominal job
        run_job();
`ifdef DCT_ARRAY_CTRL_PERF_EN
        cur = 0;
        chk("perf_cycles", perf_cycles, 1 + (K + N - 1) + N * N + 1);
`endif

        // backpressure with res_ready pattern 1,0,0,1
        load_pe();
        pat = 4'b1001;
        idx = 0;
        k = 0;
        fin = 1'b0;
        @(negedge clk);
        start = 1'b1;
        res_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 300 && !fin; c++) begin
            @(negedge clk);
            if (done) fin = 1'b1;
            else if (res_valid) begin
                cur = idx;
                chk("bp_row", res_row, idx / N);
                chk("bp_col", res_col, idx % N);
                chk("bp_data", res_data, (idx < N * N) ? pe_mem[idx] : 64'hx);
                res_ready = pat[k % 4];
                k++;
                if (res_ready) idx++;
            end
        end
        res_ready = 1'b0;
        chk("bp_finished", fin, 1);
        chk("bp_words", idx, N * N);

        // start held high through the job
        load_pe();
        dones = 0;
        fv = -1;
        busy_after = 0;
        @(negedge clk);
        start = 1'b1;
        res_ready = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (res_valid && fv < 0) fv = c;
            if (done) begin
                dones++;
                start = 1'b0;
            end
            if (c > K + N + N * N + 2 && busy) busy_after++;
        end
        cur = 0;
        chk("held_first_valid", fv, K + N + 1);
        chk("held_dones", dones, 1);
        chk("held_no_restart", busy_after, 0);

        // asynchronous reset during COMPUTE at t=3, then a clean job
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        cur = 5;
        chk("pre_rst_north_en", north_en, 1);
        chk("pre_rst_north_idx", north_idx, 3);
        #2 rst = 1'b1;
        #1 check_reset();
        @(negedge clk);
        rst = 1'b0;
        load_pe();
        run_job();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
